// File: rtl/pkg_video_stream.sv
// Shared widths, state encoding and byte-enable constants for the
// pixel-to-word packing stream path.
package pkg_video_stream;

    localparam int PIX_BYTES  = 3;
    localparam int WORD_BYTES = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pack_state_e;

    localparam logic [WORD_BYTES-1:0] KEEP_1 = 4'h1;
    localparam logic [WORD_BYTES-1:0] KEEP_2 = 4'h3;
    localparam logic [WORD_BYTES-1:0] KEEP_3 = 4'h7;
    localparam logic [WORD_BYTES-1:0] KEEP_4 = 4'hF;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI4-Stream output register; loads whenever the slot is
// empty or being drained, otherwise holds every output stable.
module axis_out_reg
    import pkg_video_stream::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_valid,
    input  logic [8*WORD_BYTES-1:0] ld_data,
    input  logic [WORD_BYTES-1:0]   ld_keep,
    input  logic                    ld_last,
    input  logic                    ld_user,
    output logic                    ld_ok,
    output logic [8*WORD_BYTES-1:0] m_tdata,
    output logic [WORD_BYTES-1:0]   m_tkeep,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    m_tuser
);

    logic                    valid_q, valid_d;
    logic [8*WORD_BYTES-1:0] data_q, data_d;
    logic [WORD_BYTES-1:0]   keep_q, keep_d;
    logic                    last_q, last_d;
    logic                    user_q, user_d;

    assign ld_ok = !valid_q || m_tready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        user_d  = user_q;
        if (ld_ok) begin
            valid_d = ld_valid;
            if (ld_valid) begin
                data_d = ld_data;
                keep_d = ld_keep;
                last_d = ld_last;
                user_d = ld_user;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

    assign m_tvalid = valid_q;
    assign m_tdata  = data_q;
    assign m_tkeep  = keep_q;
    assign m_tlast  = last_q;
    assign m_tuser  = user_q;

endmodule

// File: rtl/axis_rgb_packer.sv
// Packs 24-bit RGB beats byte-contiguously into 32-bit words, flushing a
// partial word at each end of line and recovering from mid-line SOF.
module axis_rgb_packer
    import pkg_video_stream::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [23:0]          s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    input  logic                 s_tuser,
    output logic [31:0]          m_tdata,
    output logic [3:0]           m_tkeep,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 m_tuser,
    output logic                 o_sof_err,
    output logic [ERR_CNT_W-1:0] o_sof_err_cnt
);

    pack_state_e          state_q, state_d;
    logic [1:0]           res_q, res_d;
    logic [23:0]          resid_q, resid_d;
    logic                 sof_pend_q, sof_pend_d;
    logic                 sof_err_q, sof_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        ld_ok;
    logic        w_valid;
    logic [31:0] w_data;
    logic [3:0]  w_keep;
    logic        w_last;
    logic        w_user;
    logic [1:0]  eff_res;
    logic        pend;
    logic        s_tready_c;

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        resid_d    = resid_q;
        sof_pend_d = sof_pend_q;
        sof_err_d  = 1'b0;
        err_cnt_d  = err_cnt_q;
        w_valid    = 1'b0;
        w_data     = '0;
        w_keep     = KEEP_4;
        w_last     = 1'b0;
        w_user     = 1'b0;
        s_tready_c = 1'b0;
        eff_res    = res_q;
        pend       = sof_pend_q;
        unique case (state_q)
            RUN: begin
                s_tready_c = ld_ok;
                if (s_tvalid && ld_ok) begin
                    // SOF restarts packing; any mid-line residual is dropped
                    if (s_tuser) begin
                        pend    = 1'b1;
                        eff_res = 2'd0;
                        if (res_q != 2'd0) begin
                            sof_err_d = 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + 1'b1;
                            end
                        end
                    end
                    unique case (eff_res)
                        2'd0: begin
                            if (s_tlast) begin
                                w_valid = 1'b1;
                                w_data  = {8'h00, s_tdata};
                                w_keep  = KEEP_3;
                                w_last  = 1'b1;
                                res_d   = 2'd0;
                            end else begin
                                resid_d = s_tdata;
                                res_d   = 2'd3;
                            end
                        end
                        2'd3: begin
                            w_valid = 1'b1;
                            w_data  = {s_tdata[7:0], resid_q};
                            resid_d = {8'h00, s_tdata[23:8]};
                            res_d   = 2'd2;
                            if (s_tlast) begin
                                state_d = FLUSH;
                            end
                        end
                        2'd2: begin
                            w_valid = 1'b1;
                            w_data  = {s_tdata[15:0], resid_q[15:0]};
                            resid_d = {16'h0000, s_tdata[23:16]};
                            res_d   = 2'd1;
                            if (s_tlast) begin
                                state_d = FLUSH;
                            end
                        end
                        2'd1: begin
                            w_valid = 1'b1;
                            w_data  = {s_tdata, resid_q[7:0]};
                            w_last  = s_tlast;
                            res_d   = 2'd0;
                        end
                    endcase
                    w_user     = pend;
                    sof_pend_d = pend && !w_valid;
                end
            end
            FLUSH: begin
                if (ld_ok) begin
                    w_valid    = 1'b1;
                    w_last     = 1'b1;
                    w_user     = sof_pend_q;
                    sof_pend_d = 1'b0;
                    res_d      = 2'd0;
                    state_d    = RUN;
                    if (res_q == 2'd2) begin
                        w_data = {16'h0000, resid_q[15:0]};
                        w_keep = KEEP_2;
                    end else begin
                        w_data = {24'h000000, resid_q[7:0]};
                        w_keep = KEEP_1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= RUN;
            res_q      <= 2'd0;
            resid_q    <= '0;
            sof_pend_q <= 1'b0;
            sof_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            res_q      <= res_d;
            resid_q    <= resid_d;
            sof_pend_q <= sof_pend_d;
            sof_err_q  <= sof_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    axis_out_reg u_out (
        .clk      (aclk),
        .rst_n    (aresetn),
        .ld_valid (w_valid),
        .ld_data  (w_data),
        .ld_keep  (w_keep),
        .ld_last  (w_last),
        .ld_user  (w_user),
        .ld_ok    (ld_ok),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser)
    );

    assign s_tready      = s_tready_c;
    assign o_sof_err     = sof_err_q;
    assign o_sof_err_cnt = err_cnt_q;

endmodule
